// File: rtl/recfn_to_fn_pipe.sv
// Pipelined recoded-float (recFN) to IEEE binary converter with valid/ready backpressure,
// optional NaN canonicalisation, per-result NaN classification and a sticky invalid flag.
module recfn_to_fn_pipe #(
    parameter int unsigned EXP_WIDTH = 11,
    parameter int unsigned SIG_WIDTH = 53,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned CANON_NAN = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           io_in_valid,
    output logic                           io_in_ready,
    input  logic [EXP_WIDTH+SIG_WIDTH:0]   io_in_bits,
    output logic                           io_out_valid,
    input  logic                           io_out_ready,
    output logic [EXP_WIDTH+SIG_WIDTH-1:0] io_out_bits,
    output logic                           io_out_isNaN,
    output logic                           io_out_isSNaN,
    output logic                           io_invalidSticky,
    input  logic                           io_clearFlags
);

    localparam int unsigned RW  = EXP_WIDTH + SIG_WIDTH + 1;
    localparam int unsigned OW  = EXP_WIDTH + SIG_WIDTH;
    localparam int unsigned FW  = SIG_WIDTH - 1;
    localparam int unsigned SHW = $clog2(SIG_WIDTH + 1);

    localparam logic [EXP_WIDTH:0] MIN_NORM  = (EXP_WIDTH+1)'((2 ** (EXP_WIDTH - 1)) + 2);
    localparam logic [EXP_WIDTH:0] EXP_BIAS1 = (EXP_WIDTH+1)'((2 ** (EXP_WIDTH - 1)) + 1);
    localparam logic [EXP_WIDTH:0] SIG_LIM   = (EXP_WIDTH+1)'(SIG_WIDTH);
    localparam logic [FW-1:0]      CANON_FRAC = {1'b1, {(FW-1){1'b0}}};

    localparam bit USE_S2 = (STAGES >= 2);
    localparam bit USE_S3 = (STAGES >= 3);

    // ------------------------------------------------------------------
    // Decode / classification (feeds stage 1)
    // ------------------------------------------------------------------
    logic [EXP_WIDTH:0]   w_e;
    logic [EXP_WIDTH:0]   w_shdiff;
    logic                 w_special;
    logic                 w_a_sign;
    logic                 w_a_zero;
    logic                 w_a_inf;
    logic                 w_a_nan;
    logic                 w_a_snan;
    logic                 w_a_sub;
    logic [FW-1:0]        w_a_frac;
    logic [EXP_WIDTH-1:0] w_a_exp;
    logic [SHW-1:0]       w_a_shamt;

    always_comb begin
        w_e       = io_in_bits[EXP_WIDTH+SIG_WIDTH-1 : SIG_WIDTH-1];
        w_a_frac  = io_in_bits[SIG_WIDTH-2:0];
        w_a_sign  = io_in_bits[RW-1];
        w_a_zero  = (w_e[EXP_WIDTH -: 3] == 3'b000);
        w_special = (w_e[EXP_WIDTH -: 2] == 2'b11);
        w_a_inf   = w_special & ~w_e[EXP_WIDTH-2];
        w_a_nan   = w_special & w_e[EXP_WIDTH-2];
        w_a_snan  = w_a_nan & ~w_a_frac[FW-1];
        w_a_sub   = (w_e < MIN_NORM);

        // Only the low EXP_WIDTH bits of the rebased exponent survive, so subtract modulo.
        w_a_exp = w_a_sub ? '0 : (w_e[EXP_WIDTH-1:0] - EXP_BIAS1[EXP_WIDTH-1:0]);
        if (w_special) begin
            w_a_exp = '1;
        end

        w_shdiff = MIN_NORM - w_e;
        if (!w_a_sub) begin
            w_a_shamt = '0;
        end else if (w_shdiff >= SIG_LIM) begin
            w_a_shamt = SHW'(SIG_WIDTH);
        end else begin
            w_a_shamt = w_shdiff[SHW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Handshake: each stage accepts when empty or when its successor accepts
    // ------------------------------------------------------------------
    logic r_vld_0;
    logic r_vld_1;
    logic r_vld_2;
    logic w_rdy_0;
    logic w_rdy_1;
    logic w_rdy_2;
    logic w_rdy_3;
    logic w_en_b;
    logic w_out_xfer;

    assign w_rdy_3 = io_out_ready;
    assign w_rdy_2 = USE_S3 ? (~r_vld_2 | w_rdy_3) : w_rdy_3;
    assign w_rdy_1 = USE_S2 ? (~r_vld_1 | w_rdy_2) : w_rdy_2;
    assign w_rdy_0 = ~r_vld_0 | w_rdy_1;
    assign w_en_b  = (STAGES == 1) ? w_rdy_0 : w_rdy_1;

    assign io_in_ready = w_rdy_0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_0 <= 1'b0;
            r_vld_1 <= 1'b0;
            r_vld_2 <= 1'b0;
        end else begin
            if (w_rdy_0) begin
                r_vld_0 <= io_in_valid;
            end
            if (!USE_S2) begin
                r_vld_1 <= 1'b0;
            end else if (w_rdy_1) begin
                r_vld_1 <= r_vld_0;
            end
            if (!USE_S3) begin
                r_vld_2 <= 1'b0;
            end else if (w_rdy_2) begin
                r_vld_2 <= r_vld_1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 register (decoded fields), used when STAGES >= 2
    // ------------------------------------------------------------------
    logic                 r_a_sign;
    logic                 r_a_zero;
    logic                 r_a_inf;
    logic                 r_a_nan;
    logic                 r_a_snan;
    logic                 r_a_sub;
    logic [FW-1:0]        r_a_frac;
    logic [EXP_WIDTH-1:0] r_a_exp;
    logic [SHW-1:0]       r_a_shamt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_sign  <= 1'b0;
            r_a_zero  <= 1'b0;
            r_a_inf   <= 1'b0;
            r_a_nan   <= 1'b0;
            r_a_snan  <= 1'b0;
            r_a_sub   <= 1'b0;
            r_a_frac  <= '0;
            r_a_exp   <= '0;
            r_a_shamt <= '0;
        end else if (w_rdy_0) begin
            r_a_sign  <= w_a_sign;
            r_a_zero  <= w_a_zero;
            r_a_inf   <= w_a_inf;
            r_a_nan   <= w_a_nan;
            r_a_snan  <= w_a_snan;
            r_a_sub   <= w_a_sub;
            r_a_frac  <= w_a_frac;
            r_a_exp   <= w_a_exp;
            r_a_shamt <= w_a_shamt;
        end
    end

    // ------------------------------------------------------------------
    // Assembly: subnormal shift, special-case fraction, NaN canonicalisation
    // ------------------------------------------------------------------
    logic                 w_s_sign;
    logic                 w_s_zero;
    logic                 w_s_inf;
    logic                 w_s_nan;
    logic                 w_s_snan;
    logic                 w_s_sub;
    logic [FW-1:0]        w_s_frac;
    logic [EXP_WIDTH-1:0] w_s_exp;
    logic [SHW-1:0]       w_s_shamt;
    logic [FW-1:0]        w_shifted;
    logic                 w_b_sign;
    logic [EXP_WIDTH-1:0] w_b_exp;
    logic [FW-1:0]        w_b_frac;
    logic [OW-1:0]        w_b_bits;

    always_comb begin
        if (STAGES == 1) begin
            w_s_sign  = w_a_sign;
            w_s_zero  = w_a_zero;
            w_s_inf   = w_a_inf;
            w_s_nan   = w_a_nan;
            w_s_snan  = w_a_snan;
            w_s_sub   = w_a_sub;
            w_s_frac  = w_a_frac;
            w_s_exp   = w_a_exp;
            w_s_shamt = w_a_shamt;
        end else begin
            w_s_sign  = r_a_sign;
            w_s_zero  = r_a_zero;
            w_s_inf   = r_a_inf;
            w_s_nan   = r_a_nan;
            w_s_snan  = r_a_snan;
            w_s_sub   = r_a_sub;
            w_s_frac  = r_a_frac;
            w_s_exp   = r_a_exp;
            w_s_shamt = r_a_shamt;
        end

        // Hidden bit is shifted in; a shift of SIG_WIDTH flushes everything to zero.
        w_shifted = FW'({1'b1, w_s_frac} >> w_s_shamt);

        w_b_sign = w_s_sign;
        w_b_exp  = w_s_exp;
        w_b_frac = w_s_frac;
        if (w_s_inf || w_s_zero) begin
            w_b_frac = '0;
        end else if (w_s_sub) begin
            w_b_frac = w_shifted;
        end

        if ((CANON_NAN != 0) && w_s_nan) begin
            w_b_sign = 1'b0;
            w_b_exp  = '1;
            w_b_frac = CANON_FRAC;
        end

        w_b_bits = {w_b_sign, w_b_exp, w_b_frac};
    end

    // ------------------------------------------------------------------
    // Result register (stage 1 or 2) and optional output register (stage 3)
    // ------------------------------------------------------------------
    logic [OW-1:0] r_b_bits;
    logic          r_b_nan;
    logic          r_b_snan;
    logic [OW-1:0] r_c_bits;
    logic          r_c_nan;
    logic          r_c_snan;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_b_bits <= '0;
            r_b_nan  <= 1'b0;
            r_b_snan <= 1'b0;
        end else if (w_en_b) begin
            r_b_bits <= w_b_bits;
            r_b_nan  <= w_s_nan;
            r_b_snan <= w_s_snan;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_c_bits <= '0;
            r_c_nan  <= 1'b0;
            r_c_snan <= 1'b0;
        end else if (w_rdy_2) begin
            r_c_bits <= r_b_bits;
            r_c_nan  <= r_b_nan;
            r_c_snan <= r_b_snan;
        end
    end

    always_comb begin
        if (STAGES == 1) begin
            io_out_valid = r_vld_0;
        end else if (STAGES == 2) begin
            io_out_valid = r_vld_1;
        end else begin
            io_out_valid = r_vld_2;
        end
        if (USE_S3) begin
            io_out_bits   = r_c_bits;
            io_out_isNaN  = r_c_nan;
            io_out_isSNaN = r_c_snan;
        end else begin
            io_out_bits   = r_b_bits;
            io_out_isNaN  = r_b_nan;
            io_out_isSNaN = r_b_snan;
        end
    end

    // ------------------------------------------------------------------
    // Sticky invalid flag: a delivered sNaN wins over a coincident clear
    // ------------------------------------------------------------------
    logic r_sticky;

    assign w_out_xfer = io_out_valid & io_out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky <= 1'b0;
        end else if (w_out_xfer && io_out_isSNaN) begin
            r_sticky <= 1'b1;
        end else if (io_clearFlags) begin
            r_sticky <= 1'b0;
        end
    end

    assign io_invalidSticky = r_sticky;

endmodule

// File: tb/tb_recfn_to_fn_pipe.sv
// Directed bench for recfn_to_fn_pipe: four instances (STAGES 1/2/3, and STAGES 2 with
// canonical NaN) share one input stream; expected values are hand-computed constants.
module tb_recfn_to_fn_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid;
    logic [64:0] in_bits;
    logic        out_ready;
    logic        clear_flags;

    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [3:0]  out_nan;
    logic [3:0]  out_snan;
    logic [3:0]  sticky;
    logic [63:0] out_bits [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    recfn_to_fn_pipe #(.EXP_WIDTH(11), .SIG_WIDTH(53), .STAGES(1), .CANON_NAN(0)) u_dut_s1 (
        .clk(clk), .reset_n(reset_n), .io_in_valid(in_valid), .io_in_ready(in_ready[0]),
        .io_in_bits(in_bits), .io_out_valid(out_valid[0]), .io_out_ready(out_ready),
        .io_out_bits(out_bits[0]), .io_out_isNaN(out_nan[0]), .io_out_isSNaN(out_snan[0]),
        .io_invalidSticky(sticky[0]), .io_clearFlags(clear_flags)
    );
    recfn_to_fn_pipe #(.EXP_WIDTH(11), .SIG_WIDTH(53), .STAGES(2), .CANON_NAN(0)) u_dut_s2 (
        .clk(clk), .reset_n(reset_n), .io_in_valid(in_valid), .io_in_ready(in_ready[1]),
        .io_in_bits(in_bits), .io_out_valid(out_valid[1]), .io_out_ready(out_ready),
        .io_out_bits(out_bits[1]), .io_out_isNaN(out_nan[1]), .io_out_isSNaN(out_snan[1]),
        .io_invalidSticky(sticky[1]), .io_clearFlags(clear_flags)
    );
    recfn_to_fn_pipe #(.EXP_WIDTH(11), .SIG_WIDTH(53), .STAGES(3), .CANON_NAN(0)) u_dut_s3 (
        .clk(clk), .reset_n(reset_n), .io_in_valid(in_valid), .io_in_ready(in_ready[2]),
        .io_in_bits(in_bits), .io_out_valid(out_valid[2]), .io_out_ready(out_ready),
        .io_out_bits(out_bits[2]), .io_out_isNaN(out_nan[2]), .io_out_isSNaN(out_snan[2]),
        .io_invalidSticky(sticky[2]), .io_clearFlags(clear_flags)
    );
    recfn_to_fn_pipe #(.EXP_WIDTH(11), .SIG_WIDTH(53), .STAGES(2), .CANON_NAN(1)) u_dut_cn (
        .clk(clk), .reset_n(reset_n), .io_in_valid(in_valid), .io_in_ready(in_ready[3]),
        .io_in_bits(in_bits), .io_out_valid(out_valid[3]), .io_out_ready(out_ready),
        .io_out_bits(out_bits[3]), .io_out_isNaN(out_nan[3]), .io_out_isSNaN(out_snan[3]),
        .io_invalidSticky(sticky[3]), .io_clearFlags(clear_flags)
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 2) ? 3 : 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        clear_flags = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        in_valid    = 1'b0;
        in_bits     = '0;
        out_ready   = 1'b1;
        clear_flags = 1'b0;
        reset_n     = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 4'h0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0000", out_valid);
        end
        checks++;
        if (sticky !== 4'h0) begin
            errors++;
            $display("FAIL reset_sticky: got %b want 0000", sticky);
        end
        checks++;
        if (in_ready !== 4'hF) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1111", in_ready);
        end
        reset_n = 1'b1;
        tick();
    endtask

    // One word through all four instances; checks exact latency, result, flags and sticky.
    task automatic test_vector(input string name, input logic [64:0] vin,
                               input logic [63:0] vexp, input logic vnan, input logic vsnan);
        logic [63:0] want;
        in_valid    = 1'b1;
        in_bits     = vin;
        out_ready   = 1'b1;
        clear_flags = 1'b1;
        tick();
        in_valid    = 1'b0;
        clear_flags = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (out_valid[k] !== (n == lat_of(k))) begin
                    errors++;
                    $display("FAIL %s valid dut%0d cyc%0d: got %b want %b", name, k, n,
                             out_valid[k], (n == lat_of(k)));
                end
                if (n == lat_of(k)) begin
                    want = (k == 3 && vnan) ? 64'h7FF8000000000000 : vexp;
                    checks++;
                    if (out_bits[k] !== want) begin
                        errors++;
                        $display("FAIL %s bits dut%0d: got %h want %h", name, k, out_bits[k],
                                 want);
                    end
                    checks++;
                    if (out_nan[k] !== vnan || out_snan[k] !== vsnan) begin
                        errors++;
                        $display("FAIL %s flags dut%0d: got nan=%b snan=%b want nan=%b snan=%b",
                                 name, k, out_nan[k], out_snan[k], vnan, vsnan);
                    end
                end
                checks++;
                if (sticky[k] !== (vsnan && (n > lat_of(k)))) begin
                    errors++;
                    $display("FAIL %s sticky dut%0d cyc%0d: got %b want %b", name, k, n,
                             sticky[k], (vsnan && (n > lat_of(k))));
                end
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sticky[k] !== vsnan) begin
                errors++;
                $display("FAIL %s sticky_final dut%0d: got %b want %b", name, k, sticky[k], vsnan);
            end
        end
    endtask

    task automatic test_normals();
        test_vector("one",       65'h0_8000000000000000, 64'h3FF0000000000000, 1'b0, 1'b0);
        test_vector("neg_zero",  65'h1_0000000000000000, 64'h8000000000000000, 1'b0, 1'b0);
        test_vector("neg_2p5",   65'h1_8014000000000000, 64'hC004000000000000, 1'b0, 1'b0);
        test_vector("min_norm",  65'h0_4020000000000000, 64'h0010000000000000, 1'b0, 1'b0);
    endtask

    task automatic test_subnormals();
        test_vector("sub_min",   65'h0_3CE0000000000000, 64'h0000000000000001, 1'b0, 1'b0);
        test_vector("sub_limit", 65'h0_3CD0000000000000, 64'h0000000000000000, 1'b0, 1'b0);
        test_vector("sub_sh2",   65'h0_4000000000000000, 64'h0004000000000000, 1'b0, 1'b0);
        test_vector("sub_sh1",   65'h0_4018000000000001, 64'h000C000000000000, 1'b0, 1'b0);
    endtask

    task automatic test_specials();
        test_vector("inf",  65'h0_C000000000000000, 64'h7FF0000000000000, 1'b0, 1'b0);
        test_vector("snan", 65'h0_E000000000000001, 64'h7FF0000000000001, 1'b1, 1'b1);
        test_vector("qnan", 65'h1_E008000000000000, 64'hFFF8000000000000, 1'b1, 1'b0);
    endtask

    // STAGES=2 instance under an out_ready pattern 1,0,0,1,0,0,...
    task automatic test_backpressure();
        int          tx;
        int          rx;
        int          cyc;
        logic        in_hs;
        logic        prev_stall;
        logic        want_ready;
        logic [63:0] prev_bits;
        do_reset();
        tx         = 0;
        rx         = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_bits  = '0;
        while (rx < 8 && cyc < 100) begin
            out_ready = (cyc % 3 == 0);
            in_valid  = (tx < 8);
            in_bits   = {1'b0, 64'h8000000000000000 | 64'(tx)};
            #1;
            want_ready = !((tx - rx) == 2 && !out_ready);
            checks++;
            if (in_ready[1] !== want_ready) begin
                errors++;
                $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, in_ready[1], want_ready);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid[1] !== 1'b1 || out_bits[1] !== prev_bits) begin
                    errors++;
                    $display("FAIL bp_stall_hold cyc%0d: got v=%b %h want v=1 %h", cyc,
                             out_valid[1], out_bits[1], prev_bits);
                end
            end
            if (out_valid[1] && out_ready) begin
                checks++;
                if (out_bits[1] !== (64'h3FF0000000000000 | 64'(rx))) begin
                    errors++;
                    $display("FAIL bp_order word%0d: got %h want %h", rx, out_bits[1],
                             64'h3FF0000000000000 | 64'(rx));
                end
                rx++;
            end
            in_hs      = in_valid && in_ready[1];
            prev_stall = out_valid[1] && !out_ready;
            prev_bits  = out_bits[1];
            tick();
            if (in_hs) begin
                tx++;
            end
            cyc++;
        end
        checks++;
        if (rx != 8 || tx != 8) begin
            errors++;
            $display("FAIL bp_count: got tx=%0d rx=%0d want tx=8 rx=8", tx, rx);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    // Six words on consecutive cycles with out_ready held high: no stalls anywhere.
    task automatic test_back_to_back();
        int j;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 6);
            in_bits  = {1'b0, 64'h8010000000000000 | 64'(c)};
            #1;
            for (int k = 0; k < 4; k++) begin
                if (c < 6) begin
                    checks++;
                    if (in_ready[k] !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_in_ready dut%0d cyc%0d: got %b want 1", k, c,
                                 in_ready[k]);
                    end
                end
                j = c - lat_of(k);
                checks++;
                if (out_valid[k] !== (j >= 0 && j < 6)) begin
                    errors++;
                    $display("FAIL b2b_valid dut%0d cyc%0d: got %b want %b", k, c, out_valid[k],
                             (j >= 0 && j < 6));
                end
                if (j >= 0 && j < 6) begin
                    checks++;
                    if (out_bits[k] !== (64'h4000000000000000 | 64'(j))) begin
                        errors++;
                        $display("FAIL b2b_bits dut%0d word%0d: got %h want %h", k, j,
                                 out_bits[k], 64'h4000000000000000 | 64'(j));
                    end
                end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_inflight();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bits   = 65'h0_8000000000000000;
        tick();
        in_bits   = 65'h0_8010000000000000;
        tick();
        in_valid  = 1'b0;
        checks++;
        if (out_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL inflight_pre_reset: got %b want 1", out_valid[1]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'h0) begin
            errors++;
            $display("FAIL inflight_async_drop: got %b want 0000", out_valid);
        end
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_valid !== 4'h0) begin
                errors++;
                $display("FAIL inflight_stale cyc%0d: got %b want 0000", c, out_valid);
            end
        end
    endtask

    task automatic test_clear_set();
        do_reset();
        out_ready   = 1'b1;
        clear_flags = 1'b1;
        in_valid    = 1'b1;
        in_bits     = 65'h0_E000000000000001;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid[1] !== 1'b1 || out_snan[1] !== 1'b1) begin
            errors++;
            $display("FAIL clr_snan_out: got v=%b snan=%b want v=1 snan=1", out_valid[1],
                     out_snan[1]);
        end
        tick();
        checks++;
        if (sticky[1] !== 1'b1 || sticky[3] !== 1'b1) begin
            errors++;
            $display("FAIL clr_set_wins: got s2=%b cn=%b want 1 1", sticky[1], sticky[3]);
        end
        tick();
        checks++;
        if (sticky[1] !== 1'b0) begin
            errors++;
            $display("FAIL clr_clears: got %b want 0", sticky[1]);
        end
        clear_flags = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_normals();
        test_subnormals();
        test_specials();
        test_backpressure();
        test_back_to_back();
        test_reset_inflight();
        test_clear_set();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
